// File: rtl/fx_seq_pkg.sv
// Shared types and constants for the frame-synchronous effects configuration sequencer.
// Holds the mode encoding, datapath widths and the status-LED field layout.
package fx_seq_pkg;

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } state_t;

   localparam int PATTERN_W = 3;
   localparam int STEP_W    = 4;
   localparam int LED_W     = 8;

   // Status LED layout: [7] auto, [6:4] pattern, [3] fx, [2:1] spare, [0] heartbeat
   localparam int LED_AUTO_BIT = 7;
   localparam int LED_PAT_HI   = 6;
   localparam int LED_PAT_LO   = 4;
   localparam int LED_FX_BIT   = 3;
   localparam int LED_HB_BIT   = 0;

   function automatic logic [STEP_W-1:0] next_step(input logic [STEP_W-1:0] s);
      return s + STEP_W'(1);
   endfunction

endpackage

// File: rtl/switch_debounce.sv
// Single-bit two-flop synchroniser followed by a stable-count debouncer.
// The debounced output only follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module switch_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic db
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             db_q, db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         db_d  = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db = db_q;

endmodule

// File: rtl/fx_mode_sequencer.sv
// Frame-synchronous configuration controller: debounces switches, runs manual or auto-demo
// mode, and updates pattern select / filter enable only at the start of vertical sync.
module fx_mode_sequencer
   import fx_seq_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 250000,
   parameter int   FRAMES_PER_STEP = 120,
   parameter logic VSYNC_POL       = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           sw_raw,
   input  logic                 auto_raw,
   input  logic                 vsync,
   output logic [PATTERN_W-1:0] pattern_sel,
   output logic                 fx_enable,
   output logic                 frame_tick,
   output logic [LED_W-1:0]     leds
);

   localparam int FC_W = $clog2(FRAMES_PER_STEP) + 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_STEP - 1);

   logic [4:0] raw_vec;
   logic [4:0] db_vec;
   logic [3:0] sw_db;
   logic       auto_db;

   assign raw_vec = {auto_raw, sw_raw};
   assign sw_db   = db_vec[3:0];
   assign auto_db = db_vec[4];

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_db
         switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_vec[gi]),
            .db   (db_vec[gi])
         );
      end
   endgenerate

   logic                 vsync_q;
   logic                 frame_tick_q, frame_tick_d;
   state_t               state_q, state_d;
   logic [STEP_W-1:0]    step_q, step_d, step_inc;
   logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
   logic [PATTERN_W-1:0] pattern_q, pattern_d;
   logic                 fx_q, fx_d;
   logic                 hb_q, hb_d;

   always_comb begin
      frame_tick_d = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
      state_d      = state_q;
      step_d       = step_q;
      frame_cnt_d  = frame_cnt_q;
      pattern_d    = pattern_q;
      fx_d         = fx_q;
      hb_d         = hb_q;
      step_inc     = next_step(step_q);

      // Everything below only moves on a tick, so a frame never sees a mixed configuration
      if (frame_tick_q) begin
         hb_d = ~hb_q;
         if (state_q == MANUAL) begin
            if (auto_db) begin
               state_d     = AUTO;
               step_d      = {fx_q, pattern_q};
               frame_cnt_d = '0;
            end else begin
               pattern_d = sw_db[PATTERN_W-1:0];
               fx_d      = sw_db[3];
            end
         end else begin
            if (!auto_db) begin
               state_d   = MANUAL;
               pattern_d = sw_db[PATTERN_W-1:0];
               fx_d      = sw_db[3];
            end else if (frame_cnt_q == FC_LAST) begin
               frame_cnt_d = '0;
               step_d      = step_inc;
               pattern_d   = step_inc[PATTERN_W-1:0];
               fx_d        = step_inc[3];
            end else begin
               frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q      <= ~VSYNC_POL;
         frame_tick_q <= 1'b0;
         state_q      <= MANUAL;
         step_q       <= '0;
         frame_cnt_q  <= '0;
         pattern_q    <= '0;
         fx_q         <= 1'b0;
         hb_q         <= 1'b0;
      end else begin
         vsync_q      <= vsync;
         frame_tick_q <= frame_tick_d;
         state_q      <= state_d;
         step_q       <= step_d;
         frame_cnt_q  <= frame_cnt_d;
         pattern_q    <= pattern_d;
         fx_q         <= fx_d;
         hb_q         <= hb_d;
      end
   end

   always_comb begin
      leds                         = '0;
      leds[LED_AUTO_BIT]           = (state_q == AUTO);
      leds[LED_PAT_HI:LED_PAT_LO]  = pattern_q;
      leds[LED_FX_BIT]             = fx_q;
      leds[LED_HB_BIT]             = hb_q;
   end

   assign pattern_sel = pattern_q;
   assign fx_enable   = fx_q;
   assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_fx_mode_sequencer.sv
// Directed bench for fx_mode_sequencer: expected post-tick configurations are queued as
// stimulus is driven and compared one cycle after each frame_tick.
module tb_fx_mode_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] sw_raw;
   logic       auto_raw;
   logic       vsync;
   logic [2:0] pattern_sel;
   logic       fx_enable;
   logic       frame_tick;
   logic [7:0] leds;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0] pat;
      logic       fx;
      logic [7:0] led;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   bit   tick_prev = 1'b0;

   always #5 clk = ~clk;

   fx_mode_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .FRAMES_PER_STEP(3),
      .VSYNC_POL      (1'b0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_raw     (sw_raw),
      .auto_raw   (auto_raw),
      .vsync      (vsync),
      .pattern_sel(pattern_sel),
      .fx_enable  (fx_enable),
      .frame_tick (frame_tick),
      .leds       (leds)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] p, input logic f, input logic [7:0] l, input string t);
      exp_t e;
      e.pat = p;
      e.fx  = f;
      e.led = l;
      e.tag = t;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick_pulse();
      vsync = 1'b0;
      cyc(2);
      vsync = 1'b1;
   endtask

   task automatic frame();
      vsync = 1'b1;
      cyc(48);
      tick_pulse();
   endtask

   // Outputs settle one cycle after the tick: compare then
   always @(negedge clk) begin
      if (tick_prev) begin
         exp_t e;
         check("tick_width", 32'(frame_tick), 32'd0);
         check("sb_expected_tick", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            $display("txn %s: pat=%0d fx=%0d leds=%b", e.tag, pattern_sel, fx_enable, leds);
            check({e.tag, "_pat"}, 32'(pattern_sel), 32'(e.pat));
            check({e.tag, "_fx"}, 32'(fx_enable), 32'(e.fx));
            check({e.tag, "_leds"}, 32'(leds), 32'(e.led));
         end
      end
      tick_prev = frame_tick;
   end

   logic [2:0] auto_pat [11];
   logic       auto_fx  [11];
   logic [7:0] auto_led [11];

   initial begin
      auto_pat = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0};
      auto_fx  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      auto_led = '{8'b1101_1001, 8'b1101_1000, 8'b1110_1001, 8'b1110_1000,
                   8'b1110_1001, 8'b1111_1000, 8'b1111_1001, 8'b1111_1000,
                   8'b1000_0001, 8'b1000_0000, 8'b1000_0001};

      reset    = 1'b1;
      sw_raw   = 4'b1101;
      auto_raw = 1'b0;
      vsync    = 1'b1;

      // 1: reset with switches held, then first tick applies the debounced config
      cyc(1);
      check("rst_pat", 32'(pattern_sel), 32'd0);
      check("rst_fx", 32'(fx_enable), 32'd0);
      check("rst_tick", 32'(frame_tick), 32'd0);
      check("rst_leds", 32'(leds), 32'd0);
      cyc(2);
      reset = 1'b0;
      check("post_rst_leds", 32'(leds), 32'd0);
      check("post_rst_tick", 32'(frame_tick), 32'd0);
      push(3'd5, 1'b1, 8'b0101_1001, "first_tick");
      frame();

      // 2: short glitch rejected; accepted change held until the next tick
      vsync = 1'b1;
      cyc(10);
      sw_raw = 4'b1100;
      cyc(3);
      sw_raw = 4'b1101;
      cyc(10);
      check("glitch_pat", 32'(pattern_sel), 32'd5);
      sw_raw = 4'b1100;
      cyc(8);
      check("midframe_pat", 32'(pattern_sel), 32'd5);
      check("midframe_leds", 32'(leds), 32'b0101_1001);
      cyc(17);
      push(3'd4, 1'b1, 8'b0100_1000, "change_tick");
      tick_pulse();

      // 3: enter auto from 5/1, then step every 3 ticks; 4: wrap 15 -> 0
      sw_raw = 4'b1101;
      push(3'd5, 1'b1, 8'b0101_1001, "restore5");
      frame();
      auto_raw = 1'b1;
      push(3'd5, 1'b1, 8'b1101_1000, "auto_enter");
      frame();
      for (int i = 0; i < 11; i++) begin
         push(auto_pat[i], auto_fx[i], auto_led[i], $sformatf("auto%0d", i + 1));
         frame();
      end

      // 5: auto released on a step-boundary tick -> manual wins
      sw_raw   = 4'b0010;
      auto_raw = 1'b0;
      push(3'd2, 1'b0, 8'b0010_0000, "auto_exit");
      frame();

      // 6: back into auto, then reset mid-frame with vsync low
      auto_raw = 1'b1;
      push(3'd2, 1'b0, 8'b1010_0001, "auto_reenter");
      frame();
      cyc(20);
      reset = 1'b1;
      vsync = 1'b0;
      cyc(1);
      check("rst6_pat", 32'(pattern_sel), 32'd0);
      check("rst6_fx", 32'(fx_enable), 32'd0);
      check("rst6_leds", 32'(leds), 32'd0);
      check("rst6_tick", 32'(frame_tick), 32'd0);
      reset = 1'b0;
      push(3'd0, 1'b0, 8'b0000_0001, "post_reset_tick");
      cyc(1);
      vsync = 1'b1;
      cyc(5);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
